// File: rtl/seq_param_pkg.sv
// seq_param_pkg: opcode constants, FSM state encoding and clog2 helper shared by the sequencer (no ports)
package seq_param_pkg;
  localparam logic [3:0] Seq_NOP = 4'h0, Seq_LDI = 4'h1, Seq_LDR = 4'h2, Seq_CMD = 4'h3,
                         Seq_DMP = 4'h4, Seq_EQI = 4'h5, Seq_EQR = 4'h6, Seq_JXI = 4'h7,
                         Seq_JXR = 4'h8, Seq_JZI = 4'h9, Seq_JZR = 4'hA, Seq_LCI = 4'hB,
                         Seq_DJN = 4'hC, Seq_WAI = 4'hD;
  typedef enum logic [1:0] {READY, WAIT, ERROR} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/seq_param_timer.sv
// seq_param_timer: loadable down-counter, done high while count==1 (in: clock, reset active-low, load, value; out: done)
module seq_param_timer #(
  parameter int Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] value,
  output logic             done
);
  logic [Width-1:0] cnt;
  always_ff @(posedge clock)
    if (!reset) cnt <= '0;
    else cnt <= load ? value : (cnt != '0 ? cnt - Width'(1) : cnt);
  assign done = cnt == Width'(1);
endmodule

// File: rtl/seq_param.sv
// seq_param: parametrised instruction sequencer (in: clock, reset active-low, inst, inst_en, ireg; out: inst_ready, next, oreg, oreg_wen, error)
module seq_param import seq_param_pkg::*; #(
  parameter int DataWidth   = 8,
  parameter int InRegCount  = 4,
  parameter int OutRegCount = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [3+DataWidth:0]             inst,
  input  logic                             inst_en,
  output logic                             inst_ready,
  input  logic [InRegCount*DataWidth-1:0]  ireg,
  output logic [DataWidth-1:0]             next,
  output logic [3+DataWidth:0]             oreg,
  output logic [OutRegCount-1:0]           oreg_wen,
  output logic                             error
);
  localparam int RW = clog2(InRegCount);
  localparam int OW = clog2(OutRegCount);
  state_t state, state_n;
  logic [DataWidth-1:0] acc, acc_n, cnt, cnt_n, next_n, imm, r, inc, dec;
  logic [3+DataWidth:0] oreg_n;
  logic [OutRegCount-1:0] wen_n, osel_hot;
  logic [3:0] op;
  logic error_n, accept, wai, done;
  assign op = inst[3+DataWidth -: 4];
  assign imm = inst[DataWidth-1:0];
  assign r = ireg[int'(imm[RW-1:0])*DataWidth +: DataWidth];
  assign osel_hot = OutRegCount'(1) << imm[OW-1:0];
  assign inc = next + DataWidth'(1);
  assign dec = cnt - DataWidth'(1);
  assign inst_ready = reset && state == READY;
  assign accept = inst_en && inst_ready;
  assign wai = accept && op == Seq_WAI && imm != '0;
  seq_param_timer #(.Width(DataWidth)) u_timer (
    .clock(clock),
    .reset(reset),
    .load(wai),
    .value(imm),
    .done(done)
  );
  always_comb begin
    state_n = (state == WAIT && done) ? READY : state;
    acc_n = acc;
    cnt_n = cnt;
    next_n = next;
    oreg_n = oreg;
    wen_n = '0;
    error_n = error;
    if (accept) begin
      next_n = inc;
      case (op)
        Seq_NOP: ;
        Seq_LDI: acc_n = imm;
        Seq_LDR: acc_n = r;
        Seq_CMD: begin oreg_n = {imm[DataWidth-1 -: 4], acc}; wen_n = osel_hot; end
        Seq_DMP: begin oreg_n = {4'h0, acc}; wen_n = osel_hot; end
        Seq_EQI: acc_n = acc == imm ? '0 : DataWidth'(1);
        Seq_EQR: acc_n = acc == r ? '0 : DataWidth'(1);
        Seq_JXI: next_n = imm;
        Seq_JXR: next_n = r;
        Seq_JZI: next_n = acc == '0 ? imm : inc;
        Seq_JZR: next_n = acc == '0 ? r : inc;
        Seq_LCI: cnt_n = imm;
        Seq_DJN: begin cnt_n = dec; next_n = dec != '0 ? imm : inc; end
        Seq_WAI: state_n = imm != '0 ? WAIT : READY;
        default: begin next_n = next; error_n = 1'b1; state_n = ERROR; end
      endcase
    end
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state <= READY;
      acc <= '0;
      cnt <= '0;
      next <= '0;
      oreg <= '0;
      oreg_wen <= '0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      next <= next_n;
      oreg <= oreg_n;
      oreg_wen <= wen_n;
      error <= error_n;
    end
endmodule

// File: tb/tb_seq_param.sv
// tb_seq_param: scoreboard bench for seq_param at default parameters
module tb_seq_param;
  localparam logic [3:0] NOP = 4'h0, LDI = 4'h1, LDR = 4'h2, CMD = 4'h3, DMP = 4'h4, EQI = 4'h5,
                         EQR = 4'h6, JXI = 4'h7, JXR = 4'h8, JZI = 4'h9, JZR = 4'hA, LCI = 4'hB,
                         DJN = 4'hC, WAI = 4'hD;
  typedef struct {
    string tag;
    logic rst;
    logic [3:0] op;
    logic [7:0] imm;
    logic en;
    logic [7:0] next;
    logic [11:0] oreg;
    logic [7:0] wen;
    logic err;
    logic rdy;
  } item_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [11:0] inst = '0;
  logic inst_en = 1'b0;
  logic inst_ready;
  logic [31:0] ireg = '0;
  logic [7:0] next;
  logic [11:0] oreg;
  logic [7:0] oreg_wen;
  logic error;
  int checks = 0;
  int errors = 0;
  item_t sb[$];
  seq_param dut (
    .clock(clock),
    .reset(reset),
    .inst(inst),
    .inst_en(inst_en),
    .inst_ready(inst_ready),
    .ireg(ireg),
    .next(next),
    .oreg(oreg),
    .oreg_wen(oreg_wen),
    .error(error)
  );
  always #5 clock = ~clock;
  task automatic push(input string tag, input logic rst, input logic [3:0] op, input logic [7:0] imm,
                      input logic en, input logic [7:0] nx, input logic [11:0] orv, input logic [7:0] wen,
                      input logic err, input logic rdy);
    item_t e;
    e = '{tag, rst, op, imm, en, nx, orv, wen, err, rdy};
    sb.push_back(e);
  endtask
  task automatic apply(output item_t e);
    e = sb.pop_front();
    @(negedge clock);
    reset = e.rst;
    inst = {e.op, e.imm};
    inst_en = e.en;
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    item_t e;
    push("rst_hold0", 0, LDI, 8'h12, 1, 8'h00, 12'h000, 8'h00, 0, 0);
    push("rst_hold1", 0, LDI, 8'h12, 1, 8'h00, 12'h000, 8'h00, 0, 0);
    push("rst_release", 1, NOP, 8'h00, 0, 8'h00, 12'h000, 8'h00, 0, 1);
    while (sb.size() > 0) begin
      apply(e);
      checks++;
      if ({next, oreg, oreg_wen, error, inst_ready} !== {e.next, e.oreg, e.wen, e.err, e.rdy}) begin
        errors++;
        $display("FAIL reset %s: got next=%h oreg=%h wen=%b err=%b rdy=%b want next=%h oreg=%h wen=%b err=%b rdy=%b",
                 e.tag, next, oreg, oreg_wen, error, inst_ready, e.next, e.oreg, e.wen, e.err, e.rdy);
      end
    end
  endtask
  task automatic test_acc_ops();
    item_t e;
    push("ldi_fa", 1, LDI, 8'hFA, 1, 8'h01, 12'h000, 8'h00, 0, 1);
    push("dmp_2", 1, DMP, 8'h02, 1, 8'h02, 12'h0FA, 8'h04, 0, 1);
    push("idle", 1, NOP, 8'h00, 0, 8'h02, 12'h0FA, 8'h00, 0, 1);
    push("cmd_a5", 1, CMD, 8'hA5, 1, 8'h03, 12'hAFA, 8'h20, 0, 1);
    push("nop_hold", 1, NOP, 8'h00, 1, 8'h04, 12'hAFA, 8'h00, 0, 1);
    while (sb.size() > 0) begin
      apply(e);
      checks++;
      if ({next, oreg, oreg_wen, error, inst_ready} !== {e.next, e.oreg, e.wen, e.err, e.rdy}) begin
        errors++;
        $display("FAIL acc_ops %s: got next=%h oreg=%h wen=%b err=%b rdy=%b want next=%h oreg=%h wen=%b err=%b rdy=%b",
                 e.tag, next, oreg, oreg_wen, error, inst_ready, e.next, e.oreg, e.wen, e.err, e.rdy);
      end
    end
  endtask
  task automatic test_compare();
    item_t e;
    push("ldi_aa", 1, LDI, 8'hAA, 1, 8'h05, 12'hAFA, 8'h00, 0, 1);
    push("eqi_aa", 1, EQI, 8'hAA, 1, 8'h06, 12'hAFA, 8'h00, 0, 1);
    push("jzi_taken", 1, JZI, 8'h3A, 1, 8'h3A, 12'hAFA, 8'h00, 0, 1);
    push("dmp_zero", 1, DMP, 8'h00, 1, 8'h3B, 12'h000, 8'h01, 0, 1);
    push("ldi_01", 1, LDI, 8'h01, 1, 8'h3C, 12'h000, 8'h00, 0, 1);
    push("jzi_not", 1, JZI, 8'h4A, 1, 8'h3D, 12'h000, 8'h00, 0, 1);
    push("ldi_07", 1, LDI, 8'h07, 1, 8'h3E, 12'h000, 8'h00, 0, 1);
    push("eqi_ne", 1, EQI, 8'h02, 1, 8'h3F, 12'h000, 8'h00, 0, 1);
    push("dmp_one", 1, DMP, 8'h06, 1, 8'h40, 12'h001, 8'h40, 0, 1);
    while (sb.size() > 0) begin
      apply(e);
      checks++;
      if ({next, oreg, oreg_wen, error, inst_ready} !== {e.next, e.oreg, e.wen, e.err, e.rdy}) begin
        errors++;
        $display("FAIL compare %s: got next=%h oreg=%h wen=%b err=%b rdy=%b want next=%h oreg=%h wen=%b err=%b rdy=%b",
                 e.tag, next, oreg, oreg_wen, error, inst_ready, e.next, e.oreg, e.wen, e.err, e.rdy);
      end
    end
  endtask
  task automatic test_registers();
    item_t e;
    ireg = {8'h11, 8'h2A, 8'h6A, 8'h00};
    push("ldi_0", 1, LDI, 8'h00, 1, 8'h41, 12'h001, 8'h00, 0, 1);
    push("jzr_1", 1, JZR, 8'h01, 1, 8'h6A, 12'h001, 8'h00, 0, 1);
    push("jxr_2", 1, JXR, 8'h02, 1, 8'h2A, 12'h001, 8'h00, 0, 1);
    push("ldr_1", 1, LDR, 8'h01, 1, 8'h2B, 12'h001, 8'h00, 0, 1);
    push("dmp_7", 1, DMP, 8'h07, 1, 8'h2C, 12'h06A, 8'h80, 0, 1);
    push("eqr_1", 1, EQR, 8'h01, 1, 8'h2D, 12'h06A, 8'h00, 0, 1);
    push("jzr_3", 1, JZR, 8'h03, 1, 8'h11, 12'h06A, 8'h00, 0, 1);
    push("jxi_c0", 1, JXI, 8'hC0, 1, 8'hC0, 12'h06A, 8'h00, 0, 1);
    while (sb.size() > 0) begin
      apply(e);
      checks++;
      if ({next, oreg, oreg_wen, error, inst_ready} !== {e.next, e.oreg, e.wen, e.err, e.rdy}) begin
        errors++;
        $display("FAIL registers %s: got next=%h oreg=%h wen=%b err=%b rdy=%b want next=%h oreg=%h wen=%b err=%b rdy=%b",
                 e.tag, next, oreg, oreg_wen, error, inst_ready, e.next, e.oreg, e.wen, e.err, e.rdy);
      end
    end
  endtask
  task automatic test_loop();
    item_t e;
    push("lci_3", 1, LCI, 8'h03, 1, 8'hC1, 12'h06A, 8'h00, 0, 1);
    push("djn_a", 1, DJN, 8'h10, 1, 8'h10, 12'h06A, 8'h00, 0, 1);
    push("djn_b", 1, DJN, 8'h10, 1, 8'h10, 12'h06A, 8'h00, 0, 1);
    push("djn_fall", 1, DJN, 8'h10, 1, 8'h11, 12'h06A, 8'h00, 0, 1);
    push("djn_zero_wrap", 1, DJN, 8'h20, 1, 8'h20, 12'h06A, 8'h00, 0, 1);
    push("lci_1", 1, LCI, 8'h01, 1, 8'h21, 12'h06A, 8'h00, 0, 1);
    push("djn_one", 1, DJN, 8'h30, 1, 8'h22, 12'h06A, 8'h00, 0, 1);
    while (sb.size() > 0) begin
      apply(e);
      checks++;
      if ({next, oreg, oreg_wen, error, inst_ready} !== {e.next, e.oreg, e.wen, e.err, e.rdy}) begin
        errors++;
        $display("FAIL loop %s: got next=%h oreg=%h wen=%b err=%b rdy=%b want next=%h oreg=%h wen=%b err=%b rdy=%b",
                 e.tag, next, oreg, oreg_wen, error, inst_ready, e.next, e.oreg, e.wen, e.err, e.rdy);
      end
    end
  endtask
  task automatic test_wait();
    item_t e;
    push("wai_5", 1, WAI, 8'h05, 1, 8'h23, 12'h06A, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) push("wai_stall", 1, LDI, 8'h55, 1, 8'h23, 12'h06A, 8'h00, 0, 0);
    push("wai_ready", 1, LDI, 8'h55, 1, 8'h23, 12'h06A, 8'h00, 0, 1);
    push("ldi_55", 1, LDI, 8'h55, 1, 8'h24, 12'h06A, 8'h00, 0, 1);
    push("dmp_55", 1, DMP, 8'h00, 1, 8'h25, 12'h055, 8'h01, 0, 1);
    push("wai_0", 1, WAI, 8'h00, 1, 8'h26, 12'h055, 8'h00, 0, 1);
    push("wai_1", 1, WAI, 8'h01, 1, 8'h27, 12'h055, 8'h00, 0, 0);
    push("wai_1_done", 1, NOP, 8'h00, 1, 8'h27, 12'h055, 8'h00, 0, 1);
    push("nop_after", 1, NOP, 8'h00, 1, 8'h28, 12'h055, 8'h00, 0, 1);
    while (sb.size() > 0) begin
      apply(e);
      checks++;
      if ({next, oreg, oreg_wen, error, inst_ready} !== {e.next, e.oreg, e.wen, e.err, e.rdy}) begin
        errors++;
        $display("FAIL wait %s: got next=%h oreg=%h wen=%b err=%b rdy=%b want next=%h oreg=%h wen=%b err=%b rdy=%b",
                 e.tag, next, oreg, oreg_wen, error, inst_ready, e.next, e.oreg, e.wen, e.err, e.rdy);
      end
    end
  endtask
  task automatic test_wrap();
    item_t e;
    push("jxi_ff", 1, JXI, 8'hFF, 1, 8'hFF, 12'h055, 8'h00, 0, 1);
    push("wrap_00", 1, NOP, 8'h00, 1, 8'h00, 12'h055, 8'h00, 0, 1);
    push("wrap_01", 1, NOP, 8'h00, 1, 8'h01, 12'h055, 8'h00, 0, 1);
    while (sb.size() > 0) begin
      apply(e);
      checks++;
      if ({next, oreg, oreg_wen, error, inst_ready} !== {e.next, e.oreg, e.wen, e.err, e.rdy}) begin
        errors++;
        $display("FAIL wrap %s: got next=%h oreg=%h wen=%b err=%b rdy=%b want next=%h oreg=%h wen=%b err=%b rdy=%b",
                 e.tag, next, oreg, oreg_wen, error, inst_ready, e.next, e.oreg, e.wen, e.err, e.rdy);
      end
    end
  endtask
  task automatic test_error_reset();
    item_t e;
    push("op_f", 1, 4'hF, 8'h00, 1, 8'h01, 12'h055, 8'h00, 1, 0);
    push("eqi_ignored", 1, EQI, 8'h10, 1, 8'h01, 12'h055, 8'h00, 1, 0);
    push("err_rst", 0, LDI, 8'h12, 1, 8'h00, 12'h000, 8'h00, 0, 0);
    push("ldi_ff", 1, LDI, 8'hFF, 1, 8'h01, 12'h000, 8'h00, 0, 1);
    push("dmp_ff", 1, DMP, 8'h03, 1, 8'h02, 12'h0FF, 8'h08, 0, 1);
    push("wai_9", 1, WAI, 8'h09, 1, 8'h03, 12'h0FF, 8'h00, 0, 0);
    push("wait_rst", 0, NOP, 8'h00, 0, 8'h00, 12'h000, 8'h00, 0, 0);
    push("wait_rst_out", 1, NOP, 8'h00, 0, 8'h00, 12'h000, 8'h00, 0, 1);
    push("op_e", 1, 4'hE, 8'h33, 1, 8'h00, 12'h000, 8'h00, 1, 0);
    push("err_sticky", 1, NOP, 8'h00, 0, 8'h00, 12'h000, 8'h00, 1, 0);
    while (sb.size() > 0) begin
      apply(e);
      checks++;
      if ({next, oreg, oreg_wen, error, inst_ready} !== {e.next, e.oreg, e.wen, e.err, e.rdy}) begin
        errors++;
        $display("FAIL error %s: got next=%h oreg=%h wen=%b err=%b rdy=%b want next=%h oreg=%h wen=%b err=%b rdy=%b",
                 e.tag, next, oreg, oreg_wen, error, inst_ready, e.next, e.oreg, e.wen, e.err, e.rdy);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_acc_ops();
    test_compare();
    test_registers();
    test_loop();
    test_wait();
    test_wrap();
    test_error_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
